// File: rtl/pipe_hazard_sched_if.sv
// Bus between the pipeline datapath and pipe_hazard_sched.
// The datapath drives the hazard inputs through the master modport, and the
// scheduler uses the slave modport. When HAZ_PERF_CNT_EN is defined, the
// interface also carries the two performance counters.
interface pipe_hazard_sched_if;
  // Decode-stage instruction attributes
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic       D_uses_rs;
  logic       D_uses_rt;
  logic       D_uses_hilo;
  logic       D_is_md;
  // Execute-stage instruction attributes
  logic [4:0] X_rd;
  logic       X_is_load;
  logic       X_md_start;
  logic       X_md_div;
  logic       X_br_taken;
  // Memory-stage handshake
  logic       M_mem_req;
  logic       M_mem_ack;
  // Sequencing controls
  logic       stallIF;
  logic       stallD;
  logic       stallX;
  logic       stallM;
  logic       flushD;
  logic       flushX;
  logic       md_busy;
  logic       hilo_we;
  logic       proto_err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;

  modport master (
    output D_rs, D_rt, D_uses_rs, D_uses_rt, D_uses_hilo, D_is_md,
    output X_rd, X_is_load, X_md_start, X_md_div, X_br_taken,
    output M_mem_req, M_mem_ack,
    input  stallIF, stallD, stallX, stallM, flushD, flushX,
    input  md_busy, hilo_we, proto_err,
    input  perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_uses_rs, D_uses_rt, D_uses_hilo, D_is_md,
    input  X_rd, X_is_load, X_md_start, X_md_div, X_br_taken,
    input  M_mem_req, M_mem_ack,
    output stallIF, stallD, stallX, stallM, flushD, flushX,
    output md_busy, hilo_we, proto_err,
    output perf_stall_cyc, perf_flush_cnt
  );
`else
  modport master (
    output D_rs, D_rt, D_uses_rs, D_uses_rt, D_uses_hilo, D_is_md,
    output X_rd, X_is_load, X_md_start, X_md_div, X_br_taken,
    output M_mem_req, M_mem_ack,
    input  stallIF, stallD, stallX, stallM, flushD, flushX,
    input  md_busy, hilo_we, proto_err
  );

  modport slave (
    input  D_rs, D_rt, D_uses_rs, D_uses_rt, D_uses_hilo, D_is_md,
    input  X_rd, X_is_load, X_md_start, X_md_div, X_br_taken,
    input  M_mem_req, M_mem_ack,
    output stallIF, stallD, stallX, stallM, flushD, flushX,
    output md_busy, hilo_we, proto_err
  );
`endif
endinterface

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush sequencer for the 5-stage pipeline.
// It resolves the hazards that forwarding cannot handle: memory wait,
// taken-branch squash, load-use interlock, and MUL/DIV HI/LO occupancy.
// A registered FSM with a down-counter tracks when the MUL/DIV unit is busy.
// Optional build macro: HAZ_PERF_CNT_EN adds the stall-cycle and flush-count
// counters.
module pipe_hazard_sched #(
  parameter int unsigned MUL_LAT = 4,  // 2..63
  parameter int unsigned DIV_LAT = 32  // 2..63
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_sched_if.slave bus
);

  localparam int unsigned CntW = 6;
  // The start cycle counts as one cycle of the total latency.
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

  typedef enum logic [0:0] {MdIdle, MdBusy} md_state_e;

  md_state_e      r_state_q, w_state_d;
  logic [CntW-1:0] r_cnt_q, w_cnt_d;
  logic           r_hilo_we_q, w_hilo_we_d;
  logic           r_proto_err_q, w_proto_err_d;

  logic w_md_busy;
  logic w_memwait;
  logic w_br;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_loaduse;
  logic w_mdhaz;

  logic w_stall_if;
  logic w_stall_d;
  logic w_stall_x;
  logic w_stall_m;
  logic w_flush_d;
  logic w_flush_x;

  // MUL/DIV state register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q     <= MdIdle;
      r_cnt_q       <= '0;
      r_hilo_we_q   <= 1'b0;
      r_proto_err_q <= 1'b0;
    end else begin
      r_state_q     <= w_state_d;
      r_cnt_q       <= w_cnt_d;
      r_hilo_we_q   <= w_hilo_we_d;
      r_proto_err_q <= w_proto_err_d;
    end
  end

  // MUL/DIV next state: the counter keeps running through memory stalls
  always_comb begin
    w_state_d     = r_state_q;
    w_cnt_d       = r_cnt_q;
    w_hilo_we_d   = 1'b0;
    w_proto_err_d = r_proto_err_q;
    case (r_state_q)
      MdIdle: begin
        if (bus.X_md_start) begin
          w_state_d = MdBusy;
          w_cnt_d   = bus.X_md_div ? DivLoad : MulLoad;
        end
      end
      MdBusy: begin
        w_cnt_d = r_cnt_q - CntW'(1);
        if (r_cnt_q == CntW'(1)) begin
          w_state_d   = MdIdle;
          w_hilo_we_d = 1'b1;
        end
        // A second start while busy is dropped and flagged until reset.
        if (bus.X_md_start) begin
          w_proto_err_d = 1'b1;
        end
      end
      default: begin
        w_state_d = MdIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Raw hazard terms
  always_comb begin
    w_md_busy = (r_state_q == MdBusy);
    w_memwait = bus.M_mem_req & ~bus.M_mem_ack;
    w_br      = bus.X_br_taken;
    w_rs_hit  = bus.D_uses_rs & (bus.D_rs == bus.X_rd);
    w_rt_hit  = bus.D_uses_rt & (bus.D_rt == bus.X_rd);
    // r0 is hardwired zero, so writing it creates no dependency.
    w_loaduse = bus.X_is_load & (bus.X_rd != 5'd0) & (w_rs_hit | w_rt_hit);
    w_mdhaz   = w_md_busy & (bus.D_uses_hilo | bus.D_is_md);
  end

  // Resolve hazards in priority order: memwait, branch, then interlocks
  always_comb begin
    w_stall_if = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_x  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_x  = 1'b0;
    if (!rst) begin
      if (w_memwait) begin
        // The whole pipe freezes. A taken branch stays in X and squashes
        // after the freeze is released.
        w_stall_if = 1'b1;
        w_stall_d  = 1'b1;
        w_stall_x  = 1'b1;
        w_stall_m  = 1'b1;
      end else if (w_br) begin
        // The D instruction is squashed, so its interlocks do not matter.
        w_flush_d = 1'b1;
      end else if (w_loaduse | w_mdhaz) begin
        w_stall_if = 1'b1;
        w_stall_d  = 1'b1;
        w_flush_x  = 1'b1;
      end
    end
  end

  assign bus.stallIF   = w_stall_if;
  assign bus.stallD    = w_stall_d;
  assign bus.stallX    = w_stall_x;
  assign bus.stallM    = w_stall_m;
  assign bus.flushD    = w_flush_d;
  assign bus.flushX    = w_flush_x;
  assign bus.md_busy   = w_md_busy;
  assign bus.hilo_we   = r_hilo_we_q;
  assign bus.proto_err = r_proto_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_perf_stall_q;
  logic [31:0] r_perf_flush_q;

  // Free-running performance counters; both wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall_q <= '0;
      r_perf_flush_q <= '0;
    end else begin
      if (w_stall_if) begin
        r_perf_stall_q <= r_perf_stall_q + 32'd1;
      end
      if (w_flush_d | w_flush_x) begin
        r_perf_flush_q <= r_perf_flush_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cyc = r_perf_stall_q;
  assign bus.perf_flush_cnt = r_perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Testbench for pipe_hazard_sched. It applies directed vectors and checks
// the outputs against hand-computed values. A behavioural model also checks
// the outputs every cycle. The model tracks each MUL/DIV as an absolute
// completion cycle instead of a counter.
module tb_pipe_hazard_sched;

  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 32;

  logic clk;
  logic rst;

  int n_checks;
  int n_errs;

  pipe_hazard_sched_if u_bus ();

  pipe_hazard_sched #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_cyc;     // current cycle index
  bit          m_active;  // an accepted MUL/DIV exists
  int unsigned m_done;    // cycle in which its HI/LO write occurs
  bit          m_perr;
  int unsigned m_perf_stall;
  int unsigned m_perf_flush;

  function automatic bit m_busy();
    return m_active && (m_cyc < m_done);
  endfunction

  function automatic bit m_hilo();
    return m_active && (m_cyc == m_done);
  endfunction

  // Model state moves at each clock edge from the inputs of the ending cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 0;
      m_perr   <= 1'b0;
      m_cyc    <= m_cyc + 1;
    end else begin
      if (u_bus.X_md_start) begin
        if (m_busy()) begin
          m_perr <= 1'b1;
        end else begin
          m_active <= 1'b1;
          m_done   <= m_cyc + (u_bus.X_md_div ? DivLat : MulLat);
        end
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // Expected {stallIF, stallD, stallX, stallM, flushD, flushX} for this cycle
  function automatic logic [5:0] m_ctrl();
    bit lu;
    bit mh;
    if (rst) return 6'b000000;
    if (u_bus.M_mem_req && !u_bus.M_mem_ack) return 6'b111100;
    if (u_bus.X_br_taken) return 6'b000010;
    lu = u_bus.X_is_load && (u_bus.X_rd != 0) &&
         ((u_bus.D_uses_rs && u_bus.D_rs == u_bus.X_rd) ||
          (u_bus.D_uses_rt && u_bus.D_rt == u_bus.X_rd));
    mh = m_busy() && (u_bus.D_uses_hilo || u_bus.D_is_md);
    if (lu || mh) return 6'b110001;
    return 6'b000000;
  endfunction

  // Compare process: every output, every cycle
  always @(negedge clk) begin
    logic [5:0] e;
    e = m_ctrl();
    check("cmp_stallIF", u_bus.stallIF, e[5]);
    check("cmp_stallD",  u_bus.stallD,  e[4]);
    check("cmp_stallX",  u_bus.stallX,  e[3]);
    check("cmp_stallM",  u_bus.stallM,  e[2]);
    check("cmp_flushD",  u_bus.flushD,  e[1]);
    check("cmp_flushX",  u_bus.flushX,  e[0]);
    check("cmp_md_busy", u_bus.md_busy, rst ? 1'b0 : m_busy());
    check("cmp_hilo_we", u_bus.hilo_we, rst ? 1'b0 : m_hilo());
    check("cmp_proto_err", u_bus.proto_err, rst ? 1'b0 : m_perr);
    if (rst) begin
      m_perf_stall = 0;
      m_perf_flush = 0;
    end
`ifdef HAZ_PERF_CNT_EN
    check("cmp_perf_stall", u_bus.perf_stall_cyc, m_perf_stall);
    check("cmp_perf_flush", u_bus.perf_flush_cnt, m_perf_flush);
`endif
    if (!rst) begin
      m_perf_stall = m_perf_stall + 32'(e[5]);
      m_perf_flush = m_perf_flush + 32'(e[1] | e[0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    u_bus.D_rs        = '0;
    u_bus.D_rt        = '0;
    u_bus.D_uses_rs   = 1'b0;
    u_bus.D_uses_rt   = 1'b0;
    u_bus.D_uses_hilo = 1'b0;
    u_bus.D_is_md     = 1'b0;
    u_bus.X_rd        = '0;
    u_bus.X_is_load   = 1'b0;
    u_bus.X_md_start  = 1'b0;
    u_bus.X_md_div    = 1'b0;
    u_bus.X_br_taken  = 1'b0;
    u_bus.M_mem_req   = 1'b0;
    u_bus.M_mem_ack   = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge
  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_ctrl(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {u_bus.stallIF, u_bus.stallD, u_bus.stallX, u_bus.stallM,
           u_bus.flushD, u_bus.flushX};
    check(name, act, exp);
  endtask

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] p_stall0;
  logic [31:0] p_flush0;
`endif

  initial begin
    n_checks = 0;
    n_errs   = 0;
    m_cyc    = 0;
    m_perf_stall = 0;
    m_perf_flush = 0;
    rst = 1'b1;
    clear_inputs();
    to_next();
    to_next();
    @(negedge clk);
    lit_ctrl("reset_ctrl", 6'b000000);
    check("reset_md_busy", u_bus.md_busy, 1'b0);
    check("reset_hilo_we", u_bus.hilo_we, 1'b0);
    check("reset_proto_err", u_bus.proto_err, 1'b0);
    to_next();
    rst = 1'b0;
    to_next();

    // Load-use interlock
    u_bus.X_is_load = 1'b1; u_bus.X_rd = 5'd8; u_bus.D_uses_rs = 1'b1; u_bus.D_rs = 5'd8;
    @(negedge clk); lit_ctrl("loaduse_rs", 6'b110001);
    to_next(); u_bus.X_rd = 5'd0; u_bus.D_rs = 5'd0;
    @(negedge clk); lit_ctrl("loaduse_r0", 6'b000000);
    to_next(); u_bus.X_rd = 5'd8; u_bus.D_rs = 5'd8; u_bus.D_uses_rs = 1'b0;
    @(negedge clk); lit_ctrl("loaduse_no_rs", 6'b000000);
    to_next(); u_bus.D_uses_rt = 1'b1; u_bus.D_rt = 5'd8;
    @(negedge clk); lit_ctrl("loaduse_rt", 6'b110001);
    to_next(); u_bus.D_rt = 5'd9;
    @(negedge clk); lit_ctrl("loaduse_rt_miss", 6'b000000);
    to_next(); clear_inputs();
    to_next();

    // MUL occupancy with MFHI waiting in D
    u_bus.X_md_start = 1'b1;
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk); p_stall0 = u_bus.perf_stall_cyc; p_flush0 = u_bus.perf_flush_cnt;
`endif
    for (int c = 1; c <= 5; c++) begin
      to_next();
      u_bus.X_md_start  = 1'b0;
      u_bus.D_uses_hilo = 1'b1;
      @(negedge clk);
      check("mul_busy", u_bus.md_busy, (c <= 3) ? 1'b1 : 1'b0);
      check("mul_hilo", u_bus.hilo_we, (c == 4) ? 1'b1 : 1'b0);
      lit_ctrl("mul_ctrl", (c <= 3) ? 6'b110001 : 6'b000000);
    end
`ifdef HAZ_PERF_CNT_EN
    check("perf_stall_mul", u_bus.perf_stall_cyc - p_stall0, 32'd3);
    check("perf_flush_mul", u_bus.perf_flush_cnt - p_flush0, 32'd3);
`endif
    to_next(); clear_inputs();
    to_next();

    // DIV latency unaffected by a memory wait in cycles 5..9
    u_bus.X_md_start = 1'b1; u_bus.X_md_div = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      to_next();
      clear_inputs();
      if (c >= 5 && c <= 9) u_bus.M_mem_req = 1'b1;
      if (c == 10) begin u_bus.M_mem_req = 1'b1; u_bus.M_mem_ack = 1'b1; end
      if (c == 12) u_bus.M_mem_ack = 1'b1;
      @(negedge clk);
      lit_ctrl("div_memwait", (c >= 5 && c <= 9) ? 6'b111100 : 6'b000000);
      check("div_busy", u_bus.md_busy, (c <= 31) ? 1'b1 : 1'b0);
      check("div_hilo", u_bus.hilo_we, (c == 32) ? 1'b1 : 1'b0);
    end
    to_next(); clear_inputs();

    // Priority: branch over load-use, memwait over branch
    u_bus.X_br_taken = 1'b1; u_bus.X_is_load = 1'b1; u_bus.X_rd = 5'd3;
    u_bus.D_uses_rs = 1'b1; u_bus.D_rs = 5'd3;
    @(negedge clk); lit_ctrl("prio_br_lu", 6'b000010);
    to_next(); u_bus.M_mem_req = 1'b1;
    @(negedge clk); lit_ctrl("prio_mw_br", 6'b111100);
    to_next(); u_bus.M_mem_req = 1'b0;
    @(negedge clk); lit_ctrl("prio_br_release", 6'b000010);
    to_next(); clear_inputs();
    // Branch also overrides the MUL/DIV interlock
    u_bus.X_md_start = 1'b1;
    to_next(); clear_inputs(); u_bus.D_is_md = 1'b1; u_bus.X_br_taken = 1'b1;
    @(negedge clk); lit_ctrl("prio_br_md", 6'b000010);
    to_next(); u_bus.X_br_taken = 1'b0;
    @(negedge clk); lit_ctrl("md_is_md_stall", 6'b110001);
    for (int c = 0; c < 4; c++) to_next();
    clear_inputs();

    // Second start during MUL sets proto_err; the first result still lands
    u_bus.X_md_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      to_next();
      u_bus.X_md_start = (c == 2) ? 1'b1 : 1'b0;
      u_bus.X_md_div   = (c == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("proto_err", u_bus.proto_err, (c >= 3) ? 1'b1 : 1'b0);
      check("proto_hilo", u_bus.hilo_we, (c == 4) ? 1'b1 : 1'b0);
    end

    // Reset during a MUL clears everything and no result follows
    to_next(); u_bus.X_md_start = 1'b1;
    to_next(); clear_inputs(); u_bus.D_uses_hilo = 1'b1;
    to_next();
    to_next();
    rst = 1'b1;
    #1;
    check("rst_md_busy", u_bus.md_busy, 1'b0);
    check("rst_proto_err", u_bus.proto_err, 1'b0);
    lit_ctrl("rst_ctrl", 6'b000000);
    to_next();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rst_no_hilo", u_bus.hilo_we, 1'b0);
      check("rst_no_busy", u_bus.md_busy, 1'b0);
      to_next();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
